mov_wide_encoder: RTL and testbench

MOV_WIDE_ENCODER -- requirements
Module: mov_wide_encoder

---
 rtl/legv8_pkg.sv | 6 +
 rtl/hw_next_nonzero.sv | 21 ++
 rtl/mov_wide_encoder.sv | 64 ++++++
 tb/tb_mov_wide_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 wide-move opcodes and encoder FSM states
package legv8_pkg;
  localparam logic [8:0] OPC_MOVZ = 9'b110100101;
  localparam logic [8:0] OPC_MOVK = 9'b111100101;
  typedef enum logic [1:0] {IDLE, ISSUE_Z, ISSUE_K} state_t;
endpackage

// File: rtl/hw_next_nonzero.sv
// hw_next_nonzero: first nonzero halfword at or above cur, plus whether it is the last nonzero one (built only with MOV_SKIP_ZERO_EN)
`ifdef MOV_SKIP_ZERO_EN
module hw_next_nonzero #(
  parameter int HW_COUNT = 4
) (
  input  logic [16*HW_COUNT-1:0] imm,
  input  logic [1:0]             cur,
  output logic [1:0]             nxt,
  output logic                   last
);
  // all-zero remainder falls back to cur, so imm==0 yields a single hw0 MOVZ
  always_comb begin
    nxt = cur;
    last = 1'b1;
    for (int i = HW_COUNT - 1; i >= 0; i--)
      if (i >= int'(cur) && |imm[16*i +: 16]) nxt = i[1:0];
    for (int i = 0; i < HW_COUNT; i++)
      if (i > int'(nxt) && |imm[16*i +: 16]) last = 1'b0;
  end
endmodule
`endif

// File: rtl/mov_wide_encoder.sv
// mov_wide_encoder: expands a wide constant into a LEGv8 MOVZ/MOVK sequence (MOV_SKIP_ZERO_EN skips zero halfwords)
module mov_wide_encoder
  import legv8_pkg::*;
#(
  parameter int HW_COUNT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*HW_COUNT-1:0] imm,
  input  logic [4:0]             rd,
  output logic [31:0]            instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   done
);
  state_t                 state;
  logic [1:0]             hw;
  logic [1:0]             hw_emit;
  logic                   last;
  logic [16*HW_COUNT-1:0] cap_imm;
  logic [4:0]             cap_rd;
`ifdef MOV_SKIP_ZERO_EN
  hw_next_nonzero #(.HW_COUNT(HW_COUNT)) u_next (
    .imm (cap_imm),
    .cur (hw),
    .nxt (hw_emit),
    .last(last)
  );
`else
  assign hw_emit = hw;
  assign last = hw == 2'(HW_COUNT - 1);
`endif
  assign in_ready = state == IDLE;
  assign out_valid = state != IDLE;
  assign instr = out_valid ? {state == ISSUE_Z ? OPC_MOVZ : OPC_MOVK, hw_emit, cap_imm[16*hw_emit +: 16], cap_rd} : 32'h0;
  // capture on input handshake, advance hw on output handshake, pulse done after the last one
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      hw <= 2'd0;
      cap_imm <= '0;
      cap_rd <= 5'd0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_valid && in_ready) begin
        cap_imm <= imm;
        cap_rd <= rd;
        hw <= 2'd0;
        state <= ISSUE_Z;
      end else if (out_valid && out_ready) begin
        if (last) begin
          state <= IDLE;
          done <= 1'b1;
        end else begin
          state <= ISSUE_K;
          hw <= hw_emit + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mov_wide_encoder.sv
// tb_mov_wide_encoder: directed self-checking bench for mov_wide_encoder
module tb_mov_wide_encoder;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] imm;
  logic [4:0]  rd;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] e1 [4];
  logic [31:0] e2 [4];
  int          n1;

  mov_wide_encoder #(.HW_COUNT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .imm      (imm),
    .rd       (rd),
    .instr    (instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] d);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, d);
  endtask

  initial begin
`ifdef MOV_SKIP_ZERO_EN
    e1 = '{32'hD29579A0, 32'hF2A24680, 32'hF2FFFFE0, 32'h0};
    n1 = 3;
`else
    e1 = '{32'hD29579A0, 32'hF2A24680, 32'hF2C00000, 32'hF2FFFFE0};
    n1 = 4;
`endif
    e2 = '{32'hD2800085, 32'hF2A00065, 32'hF2C00045, 32'hF2E00025};
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    imm = 64'h0;
    rd = 5'd0;
    step;
    step;
    chk("rst_instr", instr, 32'h0);
    chk_idle("rst", 32'd0);
    reset = 1'b0;
    step;
    chk_idle("post_rst", 32'd0);

    imm = 64'hFFFF_0000_1234_ABCD;
    rd = 5'd0;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    chk("seq_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < n1; i++) begin
      chk($sformatf("seq_instr%0d", i), instr, e1[i]);
      chk($sformatf("seq_valid%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("seq_nodone%0d", i), {31'b0, done}, 32'd0);
      step;
    end
    chk_idle("seq_end", 32'd1);
    step;
    chk_idle("seq_after", 32'd0);

    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    chk("stall_z", instr, e1[0]);
    step;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_hold%0d", i), instr, 32'hF2A24680);
      chk($sformatf("stall_valid%0d", i), {31'b0, out_valid}, 32'd1);
      step;
    end
    out_ready = 1'b1;
    chk("stall_release", instr, 32'hF2A24680);
    step;
    for (int i = 2; i < n1; i++) begin
      chk($sformatf("stall_instr%0d", i), instr, e1[i]);
      step;
    end
    chk_idle("stall_end", 32'd1);
    step;

    imm = 64'hFFFF_0000_1234_ABCD;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort_instr", instr, 32'h0);
    chk_idle("abort", 32'd0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("abort_nodone%0d", i), {31'b0, done}, 32'd0);
    end

    imm = 64'hFFFF_0000_1234_ABCD;
    rd = 5'd0;
    in_valid = 1'b1;
    step;
    imm = 64'h0001_0002_0003_0004;
    rd = 5'd5;
    for (int i = 0; i < n1; i++) begin
      chk($sformatf("b2b_a%0d", i), instr, e1[i]);
      step;
    end
    chk("b2b_done", {31'b0, done}, 32'd1);
    chk("b2b_ready", {31'b0, in_ready}, 32'd1);
    step;
    in_valid = 1'b0;
    chk("b2b_nodone", {31'b0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_b%0d", i), instr, e2[i]);
      chk($sformatf("b2b_bvalid%0d", i), {31'b0, out_valid}, 32'd1);
      step;
    end
    chk_idle("b2b_end", 32'd1);
    step;

`ifdef MOV_SKIP_ZERO_EN
    imm = 64'h0000_5555_0000_0000;
    rd = 5'd7;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    chk("skip_single", instr, 32'hD2CAAAA7);
    step;
    chk_idle("skip_single_end", 32'd1);
    step;
    imm = 64'h0;
    rd = 5'd3;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    chk("skip_zero", instr, 32'hD2800003);
    step;
    chk_idle("skip_zero_end", 32'd1);
    step;
`else
    imm = 64'h0;
    rd = 5'd3;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    chk("zero_z", instr, 32'hD2800003);
    step;
    chk("zero_k1", instr, 32'hF2A00003);
    step;
    chk("zero_k2", instr, 32'hF2C00003);
    step;
    chk("zero_k3", instr, 32'hF2E00003);
    step;
    chk_idle("zero_end", 32'd1);
    step;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
